// File: rtl/e203_exu_csrctrl_mch_pkg.sv
// Shared types for the multi-channel CSR controller: FSM states, CSR op
// encodings and the default response timeout.
package e203_csrctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOC,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } csr_state_e;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam int TMO_CYC_DEF = 255;

endpackage

// File: rtl/e203_exu_csrctrl_mch_chdec.sv
// Channel decoder: compares idx[11:8] against each channel selector and
// returns a one-hot hit vector, lowest channel index winning on overlap.
module e203_csr_chdec #(
    parameter int               NCH     = 2,
    parameter logic [NCH*4-1:0] CH_BASE = {4'hD, 4'hE}
) (
    input  logic [3:0]     idx_hi_i,
    output logic [NCH-1:0] hit_o,
    output logic           any_hit_o
);

    always_comb begin
        hit_o     = '0;
        any_hit_o = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!any_hit_o && (idx_hi_i == CH_BASE[4*k +: 4])) begin
                hit_o[k]  = 1'b1;
                any_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/e203_exu_csrctrl_mch.sv
// CSR access controller: routes CSR ops either to the local CSR file or to
// one of NCH external CSR channels via read/modify/write request phases.
module e203_exu_csrctrl_mch
    import e203_csrctrl_pkg::*;
#(
    parameter int               XLEN    = 32,
    parameter int               NCH     = 2,
    parameter logic [NCH*4-1:0] CH_BASE = {4'hD, 4'hE},
    parameter int               TMO_CYC = TMO_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                csr_i_valid,
    output logic                csr_i_ready,
    input  logic [1:0]          csr_i_op,
    input  logic                csr_i_rs1imm,
    input  logic [4:0]          csr_i_zimm,
    input  logic                csr_i_rs1is0,
    input  logic                csr_i_rdwen,
    input  logic [11:0]         csr_i_idx,
    input  logic [XLEN-1:0]     csr_i_rs1,

    output logic                csr_ena,
    output logic                csr_rd_en,
    output logic                csr_wr_en,
    output logic [11:0]         csr_idx,
    output logic [XLEN-1:0]     wbck_csr_dat,
    input  logic [XLEN-1:0]     read_csr_dat,
    input  logic                csr_access_ilgl,

    output logic [NCH-1:0]      ch_req_valid,
    input  logic [NCH-1:0]      ch_req_ready,
    output logic [11:0]         ch_req_addr,
    output logic                ch_req_wr,
    output logic [XLEN-1:0]     ch_req_wdata,

    input  logic [NCH-1:0]      ch_rsp_valid,
    input  logic [NCH*XLEN-1:0] ch_rsp_rdata,
    input  logic [NCH-1:0]      ch_rsp_err,
    input  logic [NCH-1:0]      ch_off,

    output logic                csr_o_valid,
    input  logic                csr_o_ready,
    output logic [XLEN-1:0]     csr_o_wbck_wdat,
    output logic                csr_o_wbck_err
);

    localparam int TW = $clog2(TMO_CYC + 1);

    csr_state_e      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [11:0]     idx_q, idx_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            rdwen_q, rdwen_d;
    logic            rs1is0_q, rs1is0_d;
    logic            err_q, err_d;
    logic [NCH-1:0]  chsel_q, chsel_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic [NCH-1:0]  dec_hit;
    logic            dec_any;
    logic [XLEN-1:0] opnd_in;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_vld;
    logic            rsp_err;
    logic            req_rdy;
    logic            tmo_hit;

    function automatic logic [XLEN-1:0] calc_new(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] op1,
                                                 input logic [XLEN-1:0] old);
        case (op)
            OP_RW:   return op1;
            OP_RS:   return op1 | old;
            OP_RC:   return ~op1 & old;
            default: return old;
        endcase
    endfunction

    e203_csr_chdec #(
        .NCH     (NCH),
        .CH_BASE (CH_BASE)
    ) u_chdec (
        .idx_hi_i  (csr_i_idx[11:8]),
        .hit_o     (dec_hit),
        .any_hit_o (dec_any)
    );

    assign opnd_in = csr_i_rs1imm ? {{(XLEN-5){1'b0}}, csr_i_zimm} : csr_i_rs1;

    // Only the latched channel is listened to; everything else is ignored.
    always_comb begin
        rsp_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chsel_q[k]) rsp_rdata = rsp_rdata | ch_rsp_rdata[k*XLEN +: XLEN];
        end
    end

    assign rsp_vld = |(ch_rsp_valid & chsel_q);
    assign rsp_err = |(ch_rsp_err & ch_rsp_valid & chsel_q);
    assign req_rdy = |(ch_req_ready & chsel_q);
    assign tmo_hit = (tmo_q == TW'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            result_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q     <= op_d;
        idx_q    <= idx_d;
        opnd_q   <= opnd_d;
        old_q    <= old_d;
        wdata_q  <= wdata_d;
        rdwen_q  <= rdwen_d;
        rs1is0_q <= rs1is0_d;
        chsel_q  <= chsel_d;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        opnd_d   = opnd_q;
        old_d    = old_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        rdwen_d  = rdwen_q;
        rs1is0_d = rs1is0_q;
        err_d    = err_q;
        chsel_d  = chsel_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (csr_i_valid) begin
                    op_d     = csr_i_op;
                    idx_d    = csr_i_idx;
                    opnd_d   = opnd_in;
                    rdwen_d  = csr_i_rdwen;
                    rs1is0_d = csr_i_rs1is0;
                    chsel_d  = dec_hit;
                    wdata_d  = opnd_in;
                    old_d    = '0;
                    result_d = '0;
                    err_d    = 1'b0;
                    if (!dec_any) begin
                        state_d = ST_LOC;
                    end else if (|(dec_hit & ch_off)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (csr_i_op == OP_RW) begin
                        state_d = ST_WR_REQ;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_LOC: begin
                result_d = read_csr_dat;
                err_d    = csr_access_ilgl;
                state_d  = ST_DONE;
            end
            ST_RD_REQ: begin
                if (req_rdy) begin
                    state_d = ST_RD_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WR_REQ: begin
                if (req_rdy) begin
                    state_d = ST_WR_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_RD_WAIT: begin
                if (rsp_vld) begin
                    old_d    = rsp_rdata;
                    result_d = rsp_rdata;
                    if (rsp_err) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (rs1is0_q) begin
                        state_d = ST_DONE;
                    end else begin
                        wdata_d = calc_new(op_q, opnd_q, rsp_rdata);
                        state_d = ST_WR_REQ;
                    end
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (rsp_vld) begin
                    // RW returns the channel's old value; RS/RC already hold it.
                    result_d = (op_q == OP_RW) ? rsp_rdata : old_q;
                    err_d    = err_q | rsp_err;
                    state_d  = ST_DONE;
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (csr_o_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        csr_i_ready  = (state_q == ST_IDLE);
        csr_ena      = 1'b0;
        csr_rd_en    = 1'b0;
        csr_wr_en    = 1'b0;
        ch_req_valid = '0;
        ch_req_wr    = 1'b0;
        csr_o_valid  = 1'b0;
        case (state_q)
            ST_LOC: begin
                csr_ena   = 1'b1;
                csr_rd_en = (op_q == OP_RS) || (op_q == OP_RC) || ((op_q == OP_RW) && rdwen_q);
                csr_wr_en = (op_q == OP_RW) || (((op_q == OP_RS) || (op_q == OP_RC)) && !rs1is0_q);
            end
            ST_RD_REQ: ch_req_valid = chsel_q;
            ST_WR_REQ: begin
                ch_req_valid = chsel_q;
                ch_req_wr    = 1'b1;
            end
            ST_DONE:   csr_o_valid = 1'b1;
            default: ;
        endcase
    end

    assign csr_idx         = idx_q;
    assign wbck_csr_dat    = calc_new(op_q, opnd_q, read_csr_dat);
    assign ch_req_addr     = idx_q;
    assign ch_req_wdata    = wdata_q;
    assign csr_o_wbck_wdat = result_q;
    assign csr_o_wbck_err  = err_q;

endmodule

// File: tb/tb_e203_exu_csrctrl_mch.sv
// Directed bench for e203_exu_csrctrl_mch: local path, channel RMW, read-only,
// timeout, channel-off, reset abandon and writeback backpressure.
module tb_e203_exu_csrctrl_mch;

    localparam logic [1:0] RW = 2'b01;
    localparam logic [1:0] RS = 2'b10;
    localparam logic [1:0] RC = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_i_valid;
    logic        csr_i_ready;
    logic [1:0]  csr_i_op;
    logic        csr_i_rs1imm;
    logic [4:0]  csr_i_zimm;
    logic        csr_i_rs1is0;
    logic        csr_i_rdwen;
    logic [11:0] csr_i_idx;
    logic [31:0] csr_i_rs1;
    logic        csr_ena;
    logic        csr_rd_en;
    logic        csr_wr_en;
    logic [11:0] csr_idx;
    logic [31:0] wbck_csr_dat;
    logic [31:0] read_csr_dat;
    logic        csr_access_ilgl;
    logic [1:0]  ch_req_valid;
    logic [1:0]  ch_req_ready;
    logic [11:0] ch_req_addr;
    logic        ch_req_wr;
    logic [31:0] ch_req_wdata;
    logic [1:0]  ch_rsp_valid;
    logic [63:0] ch_rsp_rdata;
    logic [1:0]  ch_rsp_err;
    logic [1:0]  ch_off;
    logic        csr_o_valid;
    logic        csr_o_ready;
    logic [31:0] csr_o_wbck_wdat;
    logic        csr_o_wbck_err;

    int n_asrt = 0;
    int n_fail = 0;

    e203_exu_csrctrl_mch #(
        .XLEN    (32),
        .NCH     (2),
        .CH_BASE ({4'hD, 4'hE}),
        .TMO_CYC (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .csr_i_valid     (csr_i_valid),
        .csr_i_ready     (csr_i_ready),
        .csr_i_op        (csr_i_op),
        .csr_i_rs1imm    (csr_i_rs1imm),
        .csr_i_zimm      (csr_i_zimm),
        .csr_i_rs1is0    (csr_i_rs1is0),
        .csr_i_rdwen     (csr_i_rdwen),
        .csr_i_idx       (csr_i_idx),
        .csr_i_rs1       (csr_i_rs1),
        .csr_ena         (csr_ena),
        .csr_rd_en       (csr_rd_en),
        .csr_wr_en       (csr_wr_en),
        .csr_idx         (csr_idx),
        .wbck_csr_dat    (wbck_csr_dat),
        .read_csr_dat    (read_csr_dat),
        .csr_access_ilgl (csr_access_ilgl),
        .ch_req_valid    (ch_req_valid),
        .ch_req_ready    (ch_req_ready),
        .ch_req_addr     (ch_req_addr),
        .ch_req_wr       (ch_req_wr),
        .ch_req_wdata    (ch_req_wdata),
        .ch_rsp_valid    (ch_rsp_valid),
        .ch_rsp_rdata    (ch_rsp_rdata),
        .ch_rsp_err      (ch_rsp_err),
        .ch_off          (ch_off),
        .csr_o_valid     (csr_o_valid),
        .csr_o_ready     (csr_o_ready),
        .csr_o_wbck_wdat (csr_o_wbck_wdat),
        .csr_o_wbck_err  (csr_o_wbck_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single accept edge; returns #1 after that edge.
    task automatic issue(input logic [1:0] op, input logic imm, input logic [4:0] zimm,
                         input logic is0, input logic rdwen, input logic [11:0] idx,
                         input logic [31:0] rs1);
        csr_i_valid  = 1'b1;
        csr_i_op     = op;
        csr_i_rs1imm = imm;
        csr_i_zimm   = zimm;
        csr_i_rs1is0 = is0;
        csr_i_rdwen  = rdwen;
        csr_i_idx    = idx;
        csr_i_rs1    = rs1;
        #1;
        chk("issue_ready", {31'd0, csr_i_ready}, 32'd1);
        edge1();
        csr_i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        csr_i_valid = 1'b0; csr_i_op = RW; csr_i_rs1imm = 1'b0; csr_i_zimm = '0;
        csr_i_rs1is0 = 1'b0; csr_i_rdwen = 1'b0; csr_i_idx = '0; csr_i_rs1 = '0;
        read_csr_dat = '0; csr_access_ilgl = 1'b0;
        ch_req_ready = '0; ch_rsp_valid = '0; ch_rsp_rdata = '0; ch_rsp_err = '0;
        ch_off = '0; csr_o_ready = 1'b1;
        repeat (3) edge1();
        rst = 1'b0;
        #1;
        chk("rst_i_ready", {31'd0, csr_i_ready}, 32'd1);
        chk("rst_o_valid", {31'd0, csr_o_valid}, 32'd0);
        chk("rst_req_valid", {30'd0, ch_req_valid}, 32'd0);
        chk("rst_ena", {29'd0, csr_ena, csr_rd_en, csr_wr_en}, 32'd0);
        chk("rst_wdat", csr_o_wbck_wdat, 32'd0);
        chk("rst_err", {31'd0, csr_o_wbck_err}, 32'd0);

        // Local CSRRS 0x300, rs1=8, old=1
        read_csr_dat = 32'h1;
        issue(RS, 1'b0, 5'd0, 1'b0, 1'b1, 12'h300, 32'h8);
        #1;
        chk("loc_ena", {31'd0, csr_ena}, 32'd1);
        chk("loc_rd_wr", {30'd0, csr_rd_en, csr_wr_en}, 32'd3);
        chk("loc_idx", {20'd0, csr_idx}, 32'h300);
        chk("loc_wbck", wbck_csr_dat, 32'h9);
        chk("loc_o_valid_early", {31'd0, csr_o_valid}, 32'd0);
        chk("loc_no_chreq", {30'd0, ch_req_valid}, 32'd0);
        edge1();
        chk("loc_o_valid", {31'd0, csr_o_valid}, 32'd1);
        chk("loc_wdat", csr_o_wbck_wdat, 32'h1);
        chk("loc_err", {31'd0, csr_o_wbck_err}, 32'd0);
        chk("loc_done_i_ready", {31'd0, csr_i_ready}, 32'd0);
        edge1();
        chk("loc_back_idle", {31'd0, csr_i_ready}, 32'd1);

        // Local CSRRC with rs1is0: read only, no write
        read_csr_dat = 32'h5A;
        issue(RC, 1'b1, 5'd0, 1'b1, 1'b0, 12'h340, 32'h0);
        #1;
        chk("locrc_rd_wr", {30'd0, csr_rd_en, csr_wr_en}, 32'd2);
        chk("locrc_wbck", wbck_csr_dat, 32'h5A);
        edge1();
        chk("locrc_wdat", csr_o_wbck_wdat, 32'h5A);
        edge1();

        // Channel 0 CSRRC zimm=3, ready delayed two cycles on each phase
        issue(RC, 1'b1, 5'd3, 1'b0, 1'b1, 12'hE10, 32'hFFFF_FFFF);
        #1;
        chk("rc_rdreq_valid", {30'd0, ch_req_valid}, 32'd1);
        chk("rc_rdreq_wr", {31'd0, ch_req_wr}, 32'd0);
        chk("rc_rdreq_addr", {20'd0, ch_req_addr}, 32'hE10);
        edge1();
        chk("rc_rdreq_hold", {30'd0, ch_req_valid}, 32'd1);
        edge1();
        chk("rc_rdreq_hold2", {20'd0, ch_req_addr}, 32'hE10);
        ch_req_ready = 2'b01;
        edge1();
        ch_req_ready = 2'b00;
        ch_rsp_valid = 2'b01;
        ch_rsp_rdata = {32'h0, 32'hF};
        #1;
        chk("rc_rdwait_noreq", {30'd0, ch_req_valid}, 32'd0);
        edge1();
        ch_rsp_valid = 2'b00;
        #1;
        chk("rc_wrreq_valid", {30'd0, ch_req_valid}, 32'd1);
        chk("rc_wrreq_wr", {31'd0, ch_req_wr}, 32'd1);
        chk("rc_wrreq_wdata", ch_req_wdata, 32'hC);
        edge1();
        chk("rc_wrreq_hold", ch_req_wdata, 32'hC);
        edge1();
        ch_req_ready = 2'b01;
        edge1();
        ch_req_ready = 2'b00;
        ch_rsp_valid = 2'b01;
        ch_rsp_rdata = {32'h0, 32'hC};
        edge1();
        ch_rsp_valid = 2'b00;
        #1;
        chk("rc_o_valid", {31'd0, csr_o_valid}, 32'd1);
        chk("rc_wdat", csr_o_wbck_wdat, 32'hF);
        chk("rc_err", {31'd0, csr_o_wbck_err}, 32'd0);
        edge1();

        // Channel 1 CSRRS with rs1is0: read only; stray ch0 response ignored
        issue(RS, 1'b0, 5'd0, 1'b1, 1'b1, 12'hD00, 32'h55);
        #1;
        chk("rs1_req_valid", {30'd0, ch_req_valid}, 32'd2);
        ch_req_ready = 2'b10;
        edge1();
        ch_req_ready = 2'b00;
        ch_rsp_valid = 2'b01;
        ch_rsp_rdata = {32'h0, 32'h111};
        edge1();
        #1;
        chk("rs1_stray_ignored", {31'd0, csr_o_valid}, 32'd0);
        ch_rsp_valid = 2'b10;
        ch_rsp_rdata = {32'hABCD, 32'h111};
        edge1();
        ch_rsp_valid = 2'b00;
        #1;
        chk("rs1_o_valid", {31'd0, csr_o_valid}, 32'd1);
        chk("rs1_wdat", csr_o_wbck_wdat, 32'hABCD);
        chk("rs1_no_write", {30'd0, ch_req_valid}, 32'd0);
        edge1();

        // Channel 0 CSRRW with no response: timeout after 4 wait cycles
        issue(RW, 1'b0, 5'd0, 1'b0, 1'b1, 12'hE00, 32'h1234);
        #1;
        chk("tmo_wrreq_wr", {31'd0, ch_req_wr}, 32'd1);
        chk("tmo_wrreq_wdata", ch_req_wdata, 32'h1234);
        ch_req_ready = 2'b01;
        edge1();
        ch_req_ready = 2'b00;
        repeat (3) edge1();
        chk("tmo_not_yet", {31'd0, csr_o_valid}, 32'd0);
        edge1();
        chk("tmo_o_valid", {31'd0, csr_o_valid}, 32'd1);
        chk("tmo_err", {31'd0, csr_o_wbck_err}, 32'd1);
        chk("tmo_wdat", csr_o_wbck_wdat, 32'h0);
        edge1();

        // Channel 0 switched off
        ch_off = 2'b01;
        issue(RW, 1'b0, 5'd0, 1'b0, 1'b1, 12'hE00, 32'h77);
        #1;
        chk("off_no_req", {30'd0, ch_req_valid}, 32'd0);
        chk("off_o_valid", {31'd0, csr_o_valid}, 32'd1);
        chk("off_err", {31'd0, csr_o_wbck_err}, 32'd1);
        ch_off = 2'b00;
        edge1();

        // Reset while waiting for a read response; late response ignored
        issue(RS, 1'b0, 5'd0, 1'b0, 1'b1, 12'hE20, 32'h1);
        ch_req_ready = 2'b01;
        edge1();
        ch_req_ready = 2'b00;
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        #1;
        chk("rstmid_i_ready", {31'd0, csr_i_ready}, 32'd1);
        chk("rstmid_o_valid", {31'd0, csr_o_valid}, 32'd0);
        ch_rsp_valid = 2'b01;
        ch_rsp_rdata = {32'h0, 32'hDEAD};
        edge1();
        ch_rsp_valid = 2'b00;
        #1;
        chk("late_rsp_o_valid", {31'd0, csr_o_valid}, 32'd0);
        chk("late_rsp_i_ready", {31'd0, csr_i_ready}, 32'd1);
        chk("late_rsp_no_req", {30'd0, ch_req_valid}, 32'd0);

        // Local CSRRW with illegal access, writeback held off 5 cycles
        csr_o_ready     = 1'b0;
        read_csr_dat    = 32'h77;
        csr_access_ilgl = 1'b1;
        issue(RW, 1'b0, 5'd0, 1'b0, 1'b1, 12'h305, 32'hA5);
        #1;
        chk("bp_loc_rd_wr", {30'd0, csr_rd_en, csr_wr_en}, 32'd3);
        chk("bp_loc_wbck", wbck_csr_dat, 32'hA5);
        csr_i_valid = 1'b1;
        edge1();
        csr_access_ilgl = 1'b0;
        read_csr_dat    = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_o_valid", {31'd0, csr_o_valid}, 32'd1);
            chk("bp_wdat", csr_o_wbck_wdat, 32'h77);
            chk("bp_err", {31'd0, csr_o_wbck_err}, 32'd1);
            chk("bp_i_ready", {31'd0, csr_i_ready}, 32'd0);
            edge1();
        end
        csr_o_ready = 1'b1;
        edge1();
        csr_i_valid = 1'b0;
        #1;
        chk("bp_release_idle", {31'd0, csr_i_ready}, 32'd1);
        chk("bp_release_o_valid", {31'd0, csr_o_valid}, 32'd0);
        edge1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
